beep_sched: RTL and testbench

- Arbitrates a single beeper between three requesters and sequences each granted request as a timed beep pattern: N pulses with programmable ON/OFF durations in milliseconds.
- Sits between event sources (debounced key, status logic, alarm) and the beeper pin, in place of the direct key-to-beep control path.
- Enforces a fixed-priority, non-preemptive grant and a mandatory silent gap between patterns.

---
 rtl/beep_sched.sv | 177 +++++++++++++++++
 tb/tb_beep_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/beep_sched.sv
// Single-beeper scheduler: fixed-priority, non-preemptive arbitration of NREQ
// requesters, each grant played out as N timed ON/OFF pulses followed by a silent gap.
module beep_sched #(
  parameter int TICK_DIV = 50000,
  parameter int GAP_MS   = 20,
  parameter int NREQ     = 3
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [3*NREQ-1:0]    req_cnt,
  input  logic [10*NREQ-1:0]   req_on_ms,
  input  logic [10*NREQ-1:0]   req_off_ms,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic                 busy,
  output logic                 beep,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [9:0]      GAP_T   = (GAP_MS < 1) ? 10'd1 : 10'(GAP_MS);

  // Handshake: req is a level held by the requester; gnt is one-hot and stays
  // high for the whole pattern; dropping the granted req while ON/OFF aborts.
  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [9:0]        on_q, on_d;
  logic [9:0]        off_q, off_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [9:0]        ms_q, ms_d;
  logic              beep_q, beep_d;
  logic              done_q, done_d;

  logic [NREQ-1:0]   win_oh;
  logic [2:0]        win_cnt;
  logic [9:0]        win_on;
  logic [9:0]        win_off;
  logic              any_req;
  logic              abort;
  logic              tick_wrap;
  logic [9:0]        target;
  logic              phase_end;

  // Higher indices overwrite lower ones, so the highest set bit wins.
  always_comb begin
    win_oh  = '0;
    win_cnt = '0;
    win_on  = '0;
    win_off = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_cnt   = req_cnt[3*i +: 3];
        win_on    = req_on_ms[10*i +: 10];
        win_off   = req_off_ms[10*i +: 10];
      end
    end
  end

  assign any_req   = |req;
  assign abort     = ((state_q == S_ON) || (state_q == S_OFF)) && ((req & gnt_q) == '0);
  assign tick_wrap = (pre_q == PRE_MAX);

  always_comb begin
    target = 10'd1;
    case (state_q)
      S_ON:    target = on_q;
      S_OFF:   target = off_q;
      S_GAP:   target = GAP_T;
      default: target = 10'd1;
    endcase
  end

  assign phase_end = tick_wrap && (ms_q == (target - 10'd1));

  // State register (plus pattern datapath)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
      beep_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      off_q   <= off_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      beep_q  <= beep_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_ON;
      end
      S_ON: begin
        if (abort)          state_d = S_GAP;
        else if (phase_end) state_d = (cnt_q > 3'd1) ? S_OFF : S_GAP;
      end
      S_OFF: begin
        if (abort)          state_d = S_GAP;
        else if (phase_end) state_d = S_ON;
      end
      S_GAP: begin
        if (phase_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d = cnt_q;
    on_d  = on_q;
    off_d = off_q;
    pre_d = pre_q;
    ms_d  = ms_q;

    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (tick_wrap) begin
      pre_d = '0;
      ms_d  = ms_q + 10'd1;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    // Zero-valued fields are promoted to 1 so every pattern makes a sound.
    if ((state_q == S_IDLE) && any_req) begin
      cnt_d = (win_cnt == 3'd0) ? 3'd1  : win_cnt;
      on_d  = (win_on  == 10'd0) ? 10'd1 : win_on;
      off_d = (win_off == 10'd0) ? 10'd1 : win_off;
    end else if ((state_q == S_ON) && !abort && phase_end && (cnt_q > 3'd1)) begin
      cnt_d = cnt_q - 3'd1;
    end

    if ((state_d == S_ON) || (state_d == S_OFF)) begin
      gnt_d = (state_q == S_IDLE) ? win_oh : gnt_q;
    end else begin
      gnt_d = '0;
    end

    beep_d = (state_d == S_ON);
    done_d = (state_q == S_ON) && !abort && phase_end && (cnt_q <= 3'd1);
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign beep      = beep_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched at TICK_DIV=10, GAP_MS=2: each vector is a
// hand-derived {state, gnt, busy, done, beep} value for one clock cycle.
module tb_beep_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [2:0]  req;
  logic [8:0]  req_cnt;
  logic [29:0] req_on_ms;
  logic [29:0] req_off_ms;
  logic [2:0]  gnt;
  logic        done;
  logic        busy;
  logic        beep;
  logic [1:0]  dbg_state;
  logic [7:0]  obs;

  int n_vec = 0;
  int n_err = 0;

  beep_sched #(.TICK_DIV(10), .GAP_MS(2), .NREQ(3)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req        (req),
    .req_cnt    (req_cnt),
    .req_on_ms  (req_on_ms),
    .req_off_ms (req_off_ms),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .beep       (beep),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  assign obs = {dbg_state, gnt, busy, done, beep};

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ev(input logic [1:0] st, input logic [2:0] g,
                                    input logic b, input logic d, input logic p);
    return {st, g, b, d, p};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic seg(input string tag, input int len, input logic [7:0] exp);
    for (int i = 0; i < len; i++) begin
      check_vec(tag, {24'd0, obs}, {24'd0, exp});
      tick();
    end
  endtask

  task automatic set_pat(input int idx, input logic [2:0] c, input logic [9:0] on_t,
                         input logic [9:0] off_t);
    req_cnt[3*idx +: 3]     = c;
    req_on_ms[10*idx +: 10] = on_t;
    req_off_ms[10*idx +: 10] = off_t;
  endtask

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  initial begin
    sys_rst_n  = 1'b0;
    req        = '0;
    req_cnt    = '0;
    req_on_ms  = '0;
    req_off_ms = '0;
    tick();
    tick();
    check_vec("reset", {24'd0, obs}, 32'd0);
    sys_rst_n = 1'b1;
    tick();
    seg("idle0", 2, ev(ST_IDLE, 3'b000, 0, 0, 0));

    // 1: two pulses, 30 on / 20 off, then gap
    set_pat(0, 3'd2, 10'd3, 10'd2);
    req = 3'b001;
    tick();
    seg("t1_on1",  30, ev(ST_ON,  3'b001, 1, 0, 1));
    seg("t1_off",  20, ev(ST_OFF, 3'b001, 1, 0, 0));
    seg("t1_on2",  30, ev(ST_ON,  3'b001, 1, 0, 1));
    seg("t1_done",  1, ev(ST_GAP, 3'b000, 1, 1, 0));
    req = 3'b000;
    seg("t1_gap",  19, ev(ST_GAP, 3'b000, 1, 0, 0));
    seg("t1_idle",  3, ev(ST_IDLE, 3'b000, 0, 0, 0));

    // 2: simultaneous 2 and 0, priority then back-to-back service
    req_cnt = '0; req_on_ms = '0; req_off_ms = '0;
    set_pat(2, 3'd1, 10'd1, 10'd1);
    set_pat(0, 3'd1, 10'd1, 10'd1);
    req = 3'b101;
    tick();
    seg("t2_on2",   10, ev(ST_ON,  3'b100, 1, 0, 1));
    seg("t2_done2",  1, ev(ST_GAP, 3'b000, 1, 1, 0));
    req = 3'b001;
    seg("t2_gap2",  19, ev(ST_GAP, 3'b000, 1, 0, 0));
    seg("t2_idle",   1, ev(ST_IDLE, 3'b000, 0, 0, 0));
    seg("t2_on0",   10, ev(ST_ON,  3'b001, 1, 0, 1));
    seg("t2_done0",  1, ev(ST_GAP, 3'b000, 1, 1, 0));
    req = 3'b000;
    seg("t2_gap0",  19, ev(ST_GAP, 3'b000, 1, 0, 0));
    seg("t2_idle2",  2, ev(ST_IDLE, 3'b000, 0, 0, 0));

    // 3: abort during first OFF
    req_cnt = '0; req_on_ms = '0; req_off_ms = '0;
    set_pat(0, 3'd3, 10'd5, 10'd4);
    req = 3'b001;
    tick();
    seg("t3_on",    50, ev(ST_ON,  3'b001, 1, 0, 1));
    seg("t3_off",   12, ev(ST_OFF, 3'b001, 1, 0, 0));
    req = 3'b000;
    seg("t3_offx",   1, ev(ST_OFF, 3'b001, 1, 0, 0));
    seg("t3_gap",   20, ev(ST_GAP, 3'b000, 1, 0, 0));
    seg("t3_idle",   2, ev(ST_IDLE, 3'b000, 0, 0, 0));

    // 4: zero fields promoted to 1
    req_cnt = '0; req_on_ms = '0; req_off_ms = '0;
    set_pat(1, 3'd0, 10'd0, 10'd0);
    req = 3'b010;
    tick();
    seg("t4_on",    10, ev(ST_ON,  3'b010, 1, 0, 1));
    seg("t4_done",   1, ev(ST_GAP, 3'b000, 1, 1, 0));
    req = 3'b000;
    seg("t4_gap",   19, ev(ST_GAP, 3'b000, 1, 0, 0));
    seg("t4_idle",   2, ev(ST_IDLE, 3'b000, 0, 0, 0));

    // 5: async reset mid-ON, regrant, then abort from ON
    req_cnt = '0; req_on_ms = '0; req_off_ms = '0;
    set_pat(1, 3'd4, 10'd2, 10'd1);
    req = 3'b010;
    tick();
    seg("t5_on",     5, ev(ST_ON,  3'b010, 1, 0, 1));
    sys_rst_n = 1'b0;
    #2;
    check_vec("t5_async", {24'd0, obs}, 32'd0);
    tick();
    check_vec("t5_hold", {24'd0, obs}, 32'd0);
    sys_rst_n = 1'b1;
    tick();
    seg("t5_regrant", 1, ev(ST_ON, 3'b010, 1, 0, 1));
    req = 3'b000;
    seg("t5_onx",    1, ev(ST_ON,  3'b010, 1, 0, 1));
    seg("t5_gap",   20, ev(ST_GAP, 3'b000, 1, 0, 0));
    seg("t5_idle",   2, ev(ST_IDLE, 3'b000, 0, 0, 0));

    // 6: higher priority arrives mid-pattern and waits
    req_cnt = '0; req_on_ms = '0; req_off_ms = '0;
    set_pat(0, 3'd2, 10'd1, 10'd2);
    set_pat(2, 3'd1, 10'd1, 10'd1);
    req = 3'b001;
    tick();
    seg("t6_on1",   10, ev(ST_ON,  3'b001, 1, 0, 1));
    seg("t6_offa",   5, ev(ST_OFF, 3'b001, 1, 0, 0));
    req = 3'b101;
    seg("t6_offb",  15, ev(ST_OFF, 3'b001, 1, 0, 0));
    seg("t6_on2",   10, ev(ST_ON,  3'b001, 1, 0, 1));
    seg("t6_done0",  1, ev(ST_GAP, 3'b000, 1, 1, 0));
    seg("t6_gap0",  19, ev(ST_GAP, 3'b000, 1, 0, 0));
    seg("t6_idle",   1, ev(ST_IDLE, 3'b000, 0, 0, 0));
    seg("t6_on_r2", 10, ev(ST_ON,  3'b100, 1, 0, 1));
    seg("t6_done2",  1, ev(ST_GAP, 3'b000, 1, 1, 0));
    req = 3'b000;
    seg("t6_gap2",  19, ev(ST_GAP, 3'b000, 1, 0, 0));
    seg("t6_idle2",  3, ev(ST_IDLE, 3'b000, 0, 0, 0));

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
